// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, the IF/MEM pipeline stages and the unified memory.
// slave = arbiter side, master = pipeline/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [DATA_W-1:0] m_wd;
  logic [DATA_W-1:0] m_out;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_out,
    output i_rdata, i_ack, d_rdata, d_ack, m_addr, m_we, m_wd, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_out,
    input  i_rdata, i_ack, d_rdata, d_ack, m_addr, m_we, m_wd, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of the unified memory; each access lasts ACCESS_CYCLES.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise the data port always wins.
module mem_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] COUNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t            state, state_nx;
  logic              owner, owner_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic              we_q, we_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic [3:0]        count, count_nx;
  logic              last_winner, last_winner_nx;
  logic              grant_d;

`ifdef MEM_ARB_RR_EN
  // On contention the port that did not win last time gets the memory.
  assign grant_d = bus.d_req & (~bus.i_req | ~last_winner);
`else
  assign grant_d = bus.d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      count       <= 4'd0;
      last_winner <= 1'b0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      addr_q      <= addr_nx;
      we_q        <= we_nx;
      wdata_q     <= wdata_nx;
      count       <= count_nx;
      last_winner <= last_winner_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    owner_nx       = owner;
    addr_nx        = addr_q;
    we_nx          = we_q;
    wdata_nx       = wdata_q;
    count_nx       = count;
    last_winner_nx = last_winner;
    bus.m_addr     = '0;
    bus.m_we       = 1'b0;
    bus.m_wd       = '0;
    bus.busy       = 1'b0;
    bus.i_ack      = 1'b0;
    bus.d_ack      = 1'b0;
    bus.i_rdata    = '0;
    bus.d_rdata    = '0;

    case (state)
      IDLE: begin
        if (bus.i_req | bus.d_req) begin
          state_nx = ACCESS;
          owner_nx = grant_d;
          count_nx = COUNT_INIT;
          if (grant_d) begin
            addr_nx  = bus.d_addr;
            we_nx    = bus.d_we;
            wdata_nx = bus.d_wdata;
          end else begin
            addr_nx  = bus.i_addr;
            we_nx    = 1'b0;
            wdata_nx = '0;
          end
        end
      end
      ACCESS: begin
        bus.busy   = 1'b1;
        bus.m_addr = addr_q;
        bus.m_wd   = wdata_q;
        // Final cycle: write strobe, owner's ack and read data all line up here.
        if (count == 4'd0) begin
          bus.m_we       = we_q;
          state_nx       = IDLE;
          last_winner_nx = owner;
          if (owner) begin
            bus.d_ack   = 1'b1;
            bus.d_rdata = bus.m_out;
          end else begin
            bus.i_ack   = 1'b1;
            bus.i_rdata = bus.m_out;
          end
        end else begin
          count_nx = count - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed scenarios.
// Build with MEM_ARB_RR_EN defined to exercise the round-robin contention case.
module tb_mem_arbiter;
  localparam int ADDR_W        = 16;
  localparam int DATA_W        = 32;
  localparam int ACCESS_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(ACCESS_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];

  assign bus.m_out = mem[bus.m_addr[7:2]];

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'hA5A5_0000 | k;
    mem[2] = 32'h0050_0093;
    forever begin
      @(posedge clk);
      if (bus.m_we) mem[bus.m_addr[7:2]] = bus.m_wd;
    end
  end

  // Transaction model: one outstanding access, ack in its last cycle, one idle cycle after.
  int          cyc = 0;
  bit          act = 1'b0;
  bit          t_own_d;
  bit          t_we;
  logic [15:0] t_addr;
  logic [31:0] t_wd;
  int          ack_cyc;
  bit          lastw_d = 1'b0;
  bit          rr_mode;

  initial begin
`ifdef MEM_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    for (int k = 0; k < 64; k++) ref_mem[k] = 32'hA5A5_0000 | k;
    ref_mem[2] = 32'h0050_0093;
    forever begin
      @(posedge clk or posedge rst);
      if (clk) cyc++;
      if (rst) begin
        act     = 1'b0;
        lastw_d = 1'b0;
      end else if (clk && act && cyc == ack_cyc + 1) begin
        if (t_we) ref_mem[t_addr[7:2]] = t_wd;
        act     = 1'b0;
        lastw_d = t_own_d;
      end else if (clk && !act && (bus.i_req || bus.d_req)) begin
        if (bus.i_req && bus.d_req) t_own_d = rr_mode ? !lastw_d : 1'b1;
        else                        t_own_d = bus.d_req;
        t_addr  = t_own_d ? bus.d_addr : bus.i_addr;
        t_we    = t_own_d ? bus.d_we : 1'b0;
        t_wd    = t_own_d ? bus.d_wdata : 32'h0;
        ack_cyc = cyc + ACCESS_CYCLES - 1;
        act     = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit ireq, input logic [15:0] iaddr, input bit dreq,
                               input bit dwe, input logic [15:0] daddr, input logic [31:0] dwd);
    bus.i_req   = ireq;
    bus.i_addr  = iaddr;
    bus.d_req   = dreq;
    bus.d_we    = dwe;
    bus.d_addr  = daddr;
    bus.d_wdata = dwd;
  endtask

  // Waits up to limit falling edges for the chosen ack; n is the number of edges waited.
  task automatic waitAck(input bit dport, input int limit, output int n);
    bit ok = 1'b0;
    n = 0;
    while (!ok && n < limit) begin
      @(negedge clk);
      n++;
      ok = dport ? bus.d_ack : bus.i_ack;
    end
    checkOutput(dport ? "d_ack_timeout" : "i_ack_timeout", 32'(ok), 32'd1);
  endtask

  // Every-cycle comparison of all outputs against the model.
  initial begin
    bit fin;
    forever begin
      @(negedge clk);
      fin = act && (cyc == ack_cyc);
      checkOutput("busy", 32'(bus.busy), 32'(act));
      checkOutput("m_addr", 32'(bus.m_addr), act ? 32'(t_addr) : 32'h0);
      checkOutput("m_wd", bus.m_wd, act ? t_wd : 32'h0);
      checkOutput("m_we", 32'(bus.m_we), 32'(fin && t_we));
      checkOutput("i_ack", 32'(bus.i_ack), 32'(fin && !t_own_d));
      checkOutput("d_ack", 32'(bus.d_ack), 32'(fin && t_own_d));
      checkOutput("i_rdata", bus.i_rdata, (fin && !t_own_d) ? ref_mem[t_addr[7:2]] : 32'h0);
      if (!(fin && t_own_d && t_we))
        checkOutput("d_rdata", bus.d_rdata, (fin && t_own_d) ? ref_mem[t_addr[7:2]] : 32'h0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int we_cnt;
    int i_cnt;
    int d_cnt;
    int busy_cnt;
    int seq;
    int idx [0:3];

    applyStimulus(0, 16'h0, 0, 0, 16'h0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_acks", 32'({bus.i_ack, bus.d_ack}), 32'h0);
    checkOutput("rst_m_addr", 32'(bus.m_addr), 32'h0);
    rst = 1'b0;

    // Reset in the middle of a store: nothing must be written.
    @(negedge clk);
    applyStimulus(0, 16'h0, 1, 1, 16'h0010, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("abort_busy_pre", 32'(bus.busy), 32'h1);
    checkOutput("abort_m_wd_pre", bus.m_wd, 32'hDEAD_BEEF);
    #1 rst = 1'b1;
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 32'h0);
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    checkOutput("abort_m_we", 32'(bus.m_we), 32'h0);
    checkOutput("abort_m_addr", 32'(bus.m_addr), 32'h0);
    checkOutput("abort_d_ack", 32'(bus.d_ack), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_mem4", mem[4], 32'hA5A5_0004);

    // Lone fetch from word 2.
    applyStimulus(1, 16'h0008, 0, 0, 16'h0, 32'h0);
    waitAck(1'b0, 6, n);
    checkOutput("fetch_latency", 32'(n), 32'd2);
    checkOutput("fetch_rdata", bus.i_rdata, 32'h0050_0093);
    checkOutput("fetch_d_ack", 32'(bus.d_ack), 32'h0);
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    checkOutput("fetch_pulse_width", 32'(bus.i_ack), 32'h0);

    // Store then load at 0x0020.
    applyStimulus(0, 16'h0, 1, 1, 16'h0020, 32'h1234_5678);
    we_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.m_we) we_cnt++;
      if (bus.d_ack) break;
    end
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    checkOutput("store_we_pulses", 32'(we_cnt), 32'd1);
    checkOutput("store_we_after", 32'(bus.m_we), 32'h0);
    checkOutput("store_mem8", mem[8], 32'h1234_5678);
    applyStimulus(0, 16'h0, 1, 0, 16'h0020, 32'h0);
    waitAck(1'b1, 6, n);
    checkOutput("load_rdata", bus.d_rdata, 32'h1234_5678);
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 32'h0);

    // Contention from a fresh reset, both requests held for four accesses.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 16'h0008, 1, 0, 16'h0020, 32'h0);
    i_cnt = 0;
    d_cnt = 0;
    seq   = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        if (i_cnt + d_cnt < 4) idx[i_cnt + d_cnt] = k;
        seq = (seq << 1) | int'(bus.d_ack);
        if (bus.d_ack) d_cnt++;
        else           i_cnt++;
      end
    end
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 32'h0);
    checkOutput("contend_total", 32'(i_cnt + d_cnt), 32'd4);
`ifdef MEM_ARB_RR_EN
    checkOutput("rr_order", 32'(seq), 32'b1010);
`else
    checkOutput("fixed_i_starved", 32'(i_cnt), 32'd0);
    checkOutput("fixed_order", 32'(seq), 32'b1111);
`endif
    if (i_cnt + d_cnt == 4) begin
      for (int k = 1; k < 4; k++)
        checkOutput("contend_gap", 32'(idx[k] - idx[k-1]), 32'(ACCESS_CYCLES + 1));
    end

    // Fetch request withdrawn one cycle after its grant.
    @(negedge clk);
    applyStimulus(1, 16'h0004, 0, 0, 16'h0, 32'h0);
    @(negedge clk);
    checkOutput("drop_busy", 32'(bus.busy), 32'h1);
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 32'h0);
    i_cnt    = 0;
    busy_cnt = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.i_ack) begin
        i_cnt++;
        checkOutput("drop_rdata", bus.i_rdata, 32'hA5A5_0001);
      end
      if (bus.busy) busy_cnt++;
    end
    checkOutput("drop_acks", 32'(i_cnt), 32'd1);
    checkOutput("drop_busy_cycles", 32'(busy_cnt), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). It grants one port at a time, holds the winning request's address, write-enable and write data stable for a fixed number of cycles, then acknowledges the requester. It sits between the pipeline stages and the memory, and its ack outputs feed the pipeline stall logic.

## Interface
- ADDR_W, 16, byte address width, matching the memory address port
- DATA_W, 32, data width
- ACCESS_CYCLES, 2, cycles per access in ACCESS state; legal range 1..15
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch byte address
- i_rdata  out  DATA_W  fetched word; valid only while i_ack=1
- i_ack  out  1  one-cycle completion pulse to IF
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load word; valid only while d_ack=1
- d_ack  out  1  one-cycle completion pulse to MEM stage
- m_addr  out  ADDR_W  memory address
- m_we  out  1  memory write enable
- m_wd  out  DATA_W  memory write data
- m_out  in  DATA_W  memory read data (combinational from m_addr)
- busy  out  1  1 while in ACCESS

## Operation
- States: IDLE, ACCESS. Registers: state, owner (0=I, 1=D), latched addr/we/wdata, count (4 bits), last_winner.
- IDLE: m_addr=0, m_we=0, m_wd=0, both acks 0. If any req is high at a rising edge, select the winner, latch its address (fetch: we=0, wdata=0), load count=ACCESS_CYCLES-1, and enter ACCESS.
- Arbitration: only one requester -> that requester wins. Both requesting -> D wins (fixed priority; see Configuration).
- ACCESS: m_addr/m_wd come from the latched values. m_we=latched_we only while count==0. count decrements each cycle.
- count==0 cycle: the owner's ack=1. The owner's rdata=m_out. Next state is IDLE and last_winner<=owner.
- A store asserts the ack too. d_rdata during a store ack shows m_out pre-write contents and is don't-care.
- Requester input changes after the grant are ignored. Dropping req before ack does not cancel the access: the access completes and the ack still pulses.
- Addresses pass through unaligned. The memory drops the low 2 bits. The arbiter does not check alignment.
- The non-owner's ack stays 0 and its rdata is 0.

## Timing
- Reset values: state=IDLE, all outputs 0, count=0, owner=0, last_winner=I.
- Reset mid-ACCESS aborts immediately: no ack, and m_we drops asynchronously, so no write occurs.
- Latency: req high at edge E0 (state IDLE) -> ack high during the cycle after edge E0+ACCESS_CYCLES-1. The store commits at edge E0+ACCESS_CYCLES.
- After each ack there is one mandatory IDLE cycle. Throughput is one access per ACCESS_CYCLES+1 cycles.
- A requester may present a new request in the cycle after its ack. It is arbitrated in that IDLE cycle.
- Simultaneous requests are resolved at the IDLE edge only. A request arriving during ACCESS waits.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On contention, the port not equal to last_winner wins. After reset last_winner=I, so D wins the first contention.
- MEM_ARB_RR_EN undefined: fixed priority, D always wins. last_winner is still maintained but unused.

## Test plan
- Reset: assert rst mid-ACCESS on a store (addr 0x0010, data 0xDEADBEEF). Required: acks stay 0, m_we=0, memory word 4 unchanged, state=IDLE, all outputs 0.
- Lone fetch, ACCESS_CYCLES=2, memory word 2 = 0x00500093: i_req=1, i_addr=0x0008. Required: i_ack high for exactly 1 cycle, 2 cycles after the grant edge, i_rdata=0x00500093, d_ack=0.
- Store then load: d_we=1, d_addr=0x0020, d_wdata=0x12345678, then a load from 0x0020. Required: m_we pulses for one cycle only, and the load returns 0x12345678.
- Contention, fixed priority: i_req and d_req both held continuously. Required: only D is granted. The bench checks that I never acks (starves) while D keeps requesting.
- Contention with MEM_ARB_RR_EN: both held for 4 accesses. Required: grant order D, I, D, I, with one IDLE cycle between acks.
- Request dropped after grant: i_req falls one cycle after the grant. Required: i_ack still pulses once, and there is no second grant.
